pulse_det: RTL

PULSE_DET -- requirements
Module: pulse_det

---
 rtl/pulse_pkg.sv | 24 ++
 rtl/pulse_det_if.sv | 30 +++
 rtl/pulse_det_sync.sv | 23 ++
 rtl/pulse_det.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// pulse_pkg: state encodings shared by the pulse generator and
// detector, plus a counter sizing helper.
package pulse_pkg;

    typedef enum logic [2:0] {
        WAIT  = 3'd0,
        ARMED = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        DONE  = 3'd4
    } det_state_e;

    typedef enum logic [1:0] {
        GEN_IDLE = 2'd0,
        GEN_HIGH = 2'd1,
        GEN_LOW  = 2'd2,
        GEN_GAP  = 2'd3
    } gen_state_e;

    function automatic int ctr_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pulse_det_if.sv
// pulse_det_if: window request, receive line and decision
// outputs of the burst detector.
interface pulse_det_if;

    logic en;
    logic in;
    logic active;
    logic valid;
    logic bit_out;
    logic err;

    modport master (
        output en,
        output in,
        input  active,
        input  valid,
        input  bit_out,
        input  err
    );

    modport slave (
        input  en,
        input  in,
        output active,
        output valid,
        output bit_out,
        output err
    );

endinterface

// File: rtl/pulse_det_sync.sv
// pulse_det_sync: two-flop synchroniser for an asynchronous
// receive line; output resets to 0.
module pulse_det_sync (
    input  logic clk,
    input  logic n_reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture to settle metastability.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pulse_det.sv
// pulse_det: listens for a burst of evenly timed pulses in a window.
// Define PULSE_DET_SYNC_EN to synchronise `in` (+2 cycles latency).
module pulse_det
    import pulse_pkg::*;
#(
    parameter int CLKS_PER_HALF_PERIOD = 2,
    parameter int PULSES               = 3,
    parameter int TOLERANCE            = 1,
    parameter int WINDOW_CLKS          = 16
) (
    input logic        clk,
    input logic        n_reset,
    pulse_det_if.slave bus
);

    localparam int PH_LO  = (TOLERANCE >= CLKS_PER_HALF_PERIOD) ?
                            1 : CLKS_PER_HALF_PERIOD - TOLERANCE;
    localparam int PH_HI  = CLKS_PER_HALF_PERIOD + TOLERANCE;
    localparam int PH_MAX = PH_HI + 1;
    localparam int PW     = ctr_w(PH_MAX);
    localparam int NW     = ctr_w(PULSES);
    localparam int WW     = ctr_w(WINDOW_CLKS - 1);

    localparam logic [PW-1:0] PH_ONE_V = PW'(1);
    localparam logic [PW-1:0] PH_LO_V  = PW'(PH_LO);
    localparam logic [PW-1:0] PH_MAX_V = PW'(PH_MAX);
    localparam logic [NW-1:0] PULSE_V  = NW'(PULSES);
    localparam logic [WW-1:0] WIN_V    = WW'(WINDOW_CLKS - 1);

    det_state_e    state, state_nxt;
    logic [PW-1:0] phase_ctr, phase_nxt, phase_inc;
    logic [NW-1:0] pulse_ctr, pulse_nxt, pulse_inc;
    logic [WW-1:0] win_ctr, win_nxt, win_inc;
    logic          bit_q, bit_nxt;
    logic          err_q, err_nxt;
    logic          in_s, in_q;
    logic          rise, fall;

`ifdef PULSE_DET_SYNC_EN
    pulse_det_sync u_sync (
        .clk     (clk),
        .n_reset (n_reset),
        .d       (bus.in),
        .q       (in_s)
    );
`else
    assign in_s = bus.in;
`endif

    assign rise = in_s & ~in_q;
    assign fall = ~in_s & in_q;

    assign phase_inc = (phase_ctr == PH_MAX_V) ? phase_ctr
                                               : phase_ctr + 1'b1;
    assign pulse_inc = pulse_ctr + 1'b1;
    assign win_inc   = win_ctr + 1'b1;

    // Next-state, counter and decision logic.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase_ctr;
        pulse_nxt = pulse_ctr;
        win_nxt   = win_ctr;
        bit_nxt   = bit_q;
        err_nxt   = err_q;
        unique case (state)
            WAIT: begin
                if (bus.en) begin
                    state_nxt = ARMED;
                    phase_nxt = '0;
                    pulse_nxt = '0;
                    win_nxt   = '0;
                end
            end
            ARMED: begin
                win_nxt = win_inc;
                if (rise) begin
                    state_nxt = HIGH;
                    phase_nxt = PH_ONE_V;
                end else if (win_inc >= WIN_V) begin
                    state_nxt = DONE;
                    bit_nxt   = 1'b0;
                    err_nxt   = 1'b0;
                end
            end
            HIGH: begin
                if (fall) begin
                    if (phase_ctr < PH_LO_V) begin
                        state_nxt = DONE;
                        bit_nxt   = 1'b0;
                        err_nxt   = 1'b1;
                    end else begin
                        pulse_nxt = pulse_inc;
                        if (pulse_inc == PULSE_V) begin
                            state_nxt = DONE;
                            bit_nxt   = 1'b1;
                            err_nxt   = 1'b0;
                        end else begin
                            state_nxt = LOW;
                            phase_nxt = PH_ONE_V;
                        end
                    end
                end else begin
                    phase_nxt = phase_inc;
                    if (phase_inc == PH_MAX_V) begin
                        state_nxt = DONE;
                        bit_nxt   = 1'b0;
                        err_nxt   = 1'b1;
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    if (phase_ctr < PH_LO_V) begin
                        state_nxt = DONE;
                        bit_nxt   = 1'b0;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = HIGH;
                        phase_nxt = PH_ONE_V;
                    end
                end else begin
                    phase_nxt = phase_inc;
                    if (phase_inc == PH_MAX_V) begin
                        state_nxt = DONE;
                        bit_nxt   = 1'b0;
                        err_nxt   = 1'b1;
                    end
                end
            end
            DONE:    state_nxt = WAIT;
            default: state_nxt = WAIT;
        endcase
    end

    // State, counters, edge-detect history and held decision.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= WAIT;
            phase_ctr <= '0;
            pulse_ctr <= '0;
            win_ctr   <= '0;
            in_q      <= 1'b0;
            bit_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase_ctr <= phase_nxt;
            pulse_ctr <= pulse_nxt;
            win_ctr   <= win_nxt;
            in_q      <= in_s;
            bit_q     <= bit_nxt;
            err_q     <= err_nxt;
        end
    end

    assign bus.active  = (state == ARMED) || (state == HIGH) ||
                         (state == LOW);
    assign bus.valid   = (state == DONE);
    assign bus.bit_out = bit_q;
    assign bus.err     = err_q;

endmodule
